// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler.
// Holds the state encoding, the per-requester frame lengths and the retry timeout default.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sched_state_t;

    localparam int LEN_REQ0    = 1;
    localparam int LEN_REQ1    = 2;
    localparam int TIMEOUT_DEF = 4;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// On a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        if (req == 2'b11)
            gnt_idx = ~last_grant;
        else
            gnt_idx = req[1];
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between a 1-byte and a 2-byte requester.
// Captures a frame round-robin, then strobes it out byte by byte, paced on TX_BUSY.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ0_VALID,
    input  logic [DATA_W-1:0]   REQ0_DATA,
    output logic                REQ0_ACK,
    input  logic                REQ1_VALID,
    input  logic [2*DATA_W-1:0] REQ1_DATA,
    output logic                REQ1_ACK,
    input  logic                TX_BUSY,
    output logic [DATA_W-1:0]   TX_P_DATA,
    output logic                TX_DATA_VALID,
    output logic                GRANT,
    output logic                SCHED_BUSY
);

    localparam int TMR_W = $clog2(TIMEOUT);

    sched_state_t        state;
    logic [2*DATA_W-1:0] shreg;
    logic [1:0]          byte_cnt;
    logic [TMR_W-1:0]    timer;
    logic                last_grant;
    logic                gnt_idx;
    logic                gnt_vld;

    rr_arb2 u_arb (
        .req        ({REQ1_VALID, REQ0_VALID}),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_vld    (gnt_vld)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            shreg         <= '0;
            byte_cnt      <= '0;
            timer         <= '0;
            last_grant    <= 1'b1;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            REQ0_ACK      <= 1'b0;
            REQ1_ACK      <= 1'b0;
            GRANT         <= 1'b0;
            SCHED_BUSY    <= 1'b0;
        end else begin
            TX_DATA_VALID <= 1'b0;
            REQ0_ACK      <= 1'b0;
            REQ1_ACK      <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        shreg      <= gnt_idx ? REQ1_DATA : {{DATA_W{1'b0}}, REQ0_DATA};
                        byte_cnt   <= gnt_idx ? 2'(LEN_REQ1) : 2'(LEN_REQ0);
                        GRANT      <= gnt_idx;
                        last_grant <= gnt_idx;
                        REQ0_ACK   <= ~gnt_idx;
                        REQ1_ACK   <= gnt_idx;
                        SCHED_BUSY <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!TX_BUSY) begin
                        TX_P_DATA     <= shreg[DATA_W-1:0];
                        TX_DATA_VALID <= 1'b1;
                        timer         <= '0;
                        state         <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // A strobe the transmitter never acknowledged is re-issued, so
                    // consecutive strobes of the same byte sit TIMEOUT cycles apart.
                    if (TX_BUSY) begin
                        state <= WAIT_LO;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == TMR_W'(TIMEOUT - 2))
                            state <= ISSUE;
                    end
                end
                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        if (byte_cnt > 2'd1) begin
                            shreg    <= shreg >> DATA_W;
                            byte_cnt <= byte_cnt - 2'd1;
                            state    <= ISSUE;
                        end else begin
                            byte_cnt   <= '0;
                            SCHED_BUSY <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a queue-based frame model checked every
// cycle, plus directed scenarios with hand-computed byte orders and latencies.
module tb_uart_tx_sched;

    localparam int DW = 8;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ0_VALID = 1'b0;
    logic [DW-1:0] REQ0_DATA = '0;
    logic          REQ0_ACK;
    logic          REQ1_VALID = 1'b0;
    logic [2*DW-1:0] REQ1_DATA = '0;
    logic          REQ1_ACK;
    logic          TX_BUSY;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_DATA_VALID;
    logic          GRANT;
    logic          SCHED_BUSY;

    logic tx_busy = 1'b0;
    logic man_busy = 1'b0;
    int   tx_ignore = 0;
    int   tx_hold = 10;
    assign TX_BUSY = tx_busy | man_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx_sched #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ0_VALID    (REQ0_VALID),
        .REQ0_DATA     (REQ0_DATA),
        .REQ0_ACK      (REQ0_ACK),
        .REQ1_VALID    (REQ1_VALID),
        .REQ1_DATA     (REQ1_DATA),
        .REQ1_ACK      (REQ1_ACK),
        .TX_BUSY       (TX_BUSY),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .GRANT         (GRANT),
        .SCHED_BUSY    (SCHED_BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observed strobes and acks, logged from the DUT for the directed checks.
    logic [DW-1:0] sb_b[$];
    int            sb_c[$];
    int            ak_g[$];
    int            ak_c[$];

    function automatic logic [31:0] qb(int i);
        return (i < sb_b.size()) ? 32'(sb_b[i]) : 32'hDEAD;
    endfunction
    function automatic int qc(int i);
        return (i < sb_c.size()) ? sb_c[i] : -1000;
    endfunction
    function automatic int qg(int i);
        return (i < ak_g.size()) ? ak_g[i] : 7;
    endfunction
    function automatic int qa(int i);
        return (i < ak_c.size()) ? ak_c[i] : -1000;
    endfunction

    task automatic clr();
        sb_b.delete(); sb_c.delete(); ak_g.delete(); ak_c.delete();
    endtask

    // Frame model: a queue of bytes still to go, and flags for where the current byte stands.
    logic [DW-1:0] m_q[$];
    bit   m_act, m_pend, m_seen, m_last;
    int   m_n;
    logic e_ack0, e_ack1, e_dv, e_grant, e_sb;
    logic [DW-1:0] e_pd;

    task m_reset();
        m_q.delete();
        m_act = 0; m_pend = 0; m_seen = 0; m_last = 1; m_n = 0;
        e_ack0 = 0; e_ack1 = 0; e_dv = 0; e_grant = 0; e_sb = 0; e_pd = '0;
    endtask

    task m_step();
        bit w;
        e_ack0 = 0; e_ack1 = 0; e_dv = 0;
        if (!m_act) begin
            if (REQ0_VALID || REQ1_VALID) begin
                w = (REQ0_VALID && REQ1_VALID) ? !m_last : REQ1_VALID;
                m_last = w; e_grant = w;
                m_q.delete();
                if (w) begin
                    m_q.push_back(REQ1_DATA[DW-1:0]);
                    m_q.push_back(REQ1_DATA[2*DW-1:DW]);
                    e_ack1 = 1;
                end else begin
                    m_q.push_back(REQ0_DATA);
                    e_ack0 = 1;
                end
                m_act = 1; m_pend = 1;
            end
        end else if (m_pend) begin
            if (!TX_BUSY) begin
                e_dv = 1; e_pd = m_q[0];
                m_pend = 0; m_seen = 0; m_n = 0;
            end
        end else if (!m_seen) begin
            if (TX_BUSY) m_seen = 1;
            else begin
                m_n++;
                if (m_n == TO - 1) m_pend = 1;
            end
        end else if (!TX_BUSY) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_act = 0;
            else m_pend = 1;
        end
        e_sb = m_act;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) m_reset();
            else m_step();
        end
    end

    // Per-cycle compare against the model, and logging.
    initial forever begin
        @(negedge CLK);
        chk("ack0", REQ0_ACK, e_ack0);
        chk("ack1", REQ1_ACK, e_ack1);
        chk("data_valid", TX_DATA_VALID, e_dv);
        chk("p_data", TX_P_DATA, e_pd);
        chk("grant", GRANT, e_grant);
        chk("sched_busy", SCHED_BUSY, e_sb);
        if (TX_DATA_VALID) begin
            chk("strobe_while_busy", TX_BUSY, 0);
            sb_b.push_back(TX_P_DATA); sb_c.push_back(cyc);
        end
        if (REQ0_ACK) begin ak_g.push_back(0); ak_c.push_back(cyc); end
        if (REQ1_ACK) begin ak_g.push_back(1); ak_c.push_back(cyc); end
    end

    // Transmitter model: busy rises the cycle after a strobe and stays up tx_hold cycles.
    initial forever begin
        @(negedge CLK);
        if (TX_DATA_VALID && RST) begin
            if (tx_ignore > 0) tx_ignore--;
            else begin
                @(posedge CLK); #1 tx_busy = 1'b1;
                repeat (tx_hold) @(posedge CLK);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic send(input bit r, input logic [2*DW-1:0] d, output int vcyc);
        logic got;
        vcyc = cyc;
        if (r) begin REQ1_DATA = d; REQ1_VALID = 1'b1; end
        else begin REQ0_DATA = d[DW-1:0]; REQ0_VALID = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge CLK); #1;
            got = r ? REQ1_ACK : REQ0_ACK;
        end
        chk(r ? "ack1_seen" : "ack0_seen", got, 1);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        do begin @(posedge CLK); #1; i++; end while ((SCHED_BUSY || TX_BUSY) && i < 400);
        chk("idle_reached", {30'b0, SCHED_BUSY, TX_BUSY}, 0);
        repeat (2) @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int v, n, rel;
        logic [DW-1:0] exp3 [6];
        exp3 = '{8'h10, 8'h20, 8'h21, 8'h11, 8'h22, 8'h23};

        repeat (3) @(posedge CLK); #1;
        chk("rst_ack0", REQ0_ACK, 0);
        chk("rst_ack1", REQ1_ACK, 0);
        chk("rst_dv", TX_DATA_VALID, 0);
        chk("rst_pdata", TX_P_DATA, 0);
        chk("rst_grant", GRANT, 0);
        chk("rst_sbusy", SCHED_BUSY, 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK); #1;

        // Single byte
        clr();
        send(0, 16'h00A5, v);
        wait_idle();
        chk("t1_nstrobe", sb_b.size(), 1);
        chk("t1_byte", qb(0), 8'hA5);
        chk("t1_ack_lat", qa(0) - v, 1);
        chk("t1_strobe_lat", qc(0) - v, 2);

        // Two-byte frame, low byte first
        clr();
        send(1, 16'h1234, v);
        wait_idle();
        chk("t2_nstrobe", sb_b.size(), 2);
        chk("t2_byte0", qb(0), 8'h34);
        chk("t2_byte1", qb(1), 8'h12);
        chk("t2_gap", qc(1) - qc(0), 13);
        chk("t2_nack", ak_g.size(), 1);
        chk("t2_ackreq", qg(0), 1);

        // Contention: both held valid for four frames
        clr();
        REQ0_DATA = 8'h10; REQ1_DATA = 16'h2120;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        n = 0;
        for (int i = 0; i < 600 && n < 4; i++) begin
            @(posedge CLK); #1;
            if (REQ0_ACK) begin n++; REQ0_DATA = REQ0_DATA + 8'h01; end
            if (REQ1_ACK) begin n++; REQ1_DATA = REQ1_DATA + 16'h0202; end
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        wait_idle();
        chk("t3_nack", ak_g.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_order", qg(i), i % 2);
        chk("t3_nstrobe", sb_b.size(), 6);
        for (int i = 0; i < 6; i++) chk("t3_byte", qb(i), exp3[i]);

        // Lost strobe: first strobe ignored, retry after TIMEOUT cycles
        clr();
        tx_ignore = 1;
        send(0, 16'h005A, v);
        wait_idle();
        chk("t4_nstrobe", sb_b.size(), 2);
        chk("t4_byte0", qb(0), 8'h5A);
        chk("t4_byte1", qb(1), 8'h5A);
        chk("t4_retry_gap", qc(1) - qc(0), TO);

        // Transmitter busy when the frame is captured
        clr();
        man_busy = 1'b1;
        send(0, 16'h00C3, v);
        repeat (6) @(posedge CLK); #1;
        chk("t5_held", sb_b.size(), 0);
        rel = cyc;
        man_busy = 1'b0;
        wait_idle();
        chk("t5_nstrobe", sb_b.size(), 1);
        chk("t5_byte", qb(0), 8'hC3);
        chk("t5_lat", qc(0) - rel, 1);

        // Reset while the second byte of a REQ1 frame is in flight
        clr();
        send(1, 16'hBEEF, v);
        for (int i = 0; i < 100 && sb_b.size() < 2; i++) begin @(posedge CLK); #1; end
        chk("t6_byte1", qb(1), 8'hBE);
        repeat (3) @(posedge CLK);
        @(negedge CLK); #2;
        RST = 1'b0;
        #1;
        chk("t6_ack0", REQ0_ACK, 0);
        chk("t6_ack1", REQ1_ACK, 0);
        chk("t6_dv", TX_DATA_VALID, 0);
        chk("t6_pdata", TX_P_DATA, 0);
        chk("t6_grant", GRANT, 0);
        chk("t6_sbusy", SCHED_BUSY, 0);
        repeat (2) @(posedge CLK); #1;
        RST = 1'b1;
        clr();
        repeat (20) @(posedge CLK); #1;
        chk("t6_no_strobe", sb_b.size(), 0);
        chk("t6_no_ack", ak_g.size(), 0);
        wait_idle();

        // After reset a tie goes to requester 0
        clr();
        REQ0_DATA = 8'h77; REQ1_DATA = 16'h9988;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        for (int i = 0; i < 50 && !REQ0_ACK && !REQ1_ACK; i++) begin @(posedge CLK); #1; end
        chk("t7_first_ack0", REQ0_ACK, 1);
        chk("t7_first_grant", GRANT, 0);
        REQ0_VALID = 1'b0;
        for (int i = 0; i < 200 && !REQ1_ACK; i++) begin @(posedge CLK); #1; end
        REQ1_VALID = 1'b0;
        wait_idle();
        chk("t7_order0", qg(0), 0);
        chk("t7_order1", qg(1), 1);
        chk("t7_byte0", qb(0), 8'h77);
        chk("t7_byte1", qb(1), 8'h88);
        chk("t7_byte2", qb(2), 8'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
